// File: rtl/softex_pkg.sv
// Shared types and constants for the Softex softmax accelerator.
// This file holds the slot register file types, the slot response record and the slot initialisation helper.
package softex_pkg;

  localparam int unsigned SLOT_ADDR_BITS  = 8;
  localparam int unsigned NUM_LANES       = 4;
  localparam int unsigned WIDTH_IN        = 16;
  localparam int unsigned WIDTH_ACC       = 32;
  localparam int unsigned N_SLOTS_DEFAULT = 4;

  // -inf in FP16ALT, so the first real maximum always wins.
  localparam logic [WIDTH_IN-1:0] SLOT_MAX_INIT = 16'hFF80;

  typedef logic [SLOT_ADDR_BITS-1:0]             slot_addr_t;
  typedef logic [NUM_LANES-1:0][WIDTH_IN-1:0]    lane_max_t;
  typedef logic [NUM_LANES-1:0][WIDTH_ACC-1:0]   lane_den_t;

  typedef enum logic {
    SLOT_REQ_ALLOC = 1'b0,
    SLOT_REQ_LOAD  = 1'b1
  } slot_req_kind_e;

  typedef enum logic {
    SLOT_UPD_UPDATE = 1'b0,
    SLOT_UPD_FREE   = 1'b1
  } slot_upd_kind_e;

  typedef struct packed {
    lane_max_t maximum;
    lane_den_t denominator;
    logic      valid;
  } slot_t;

  typedef struct packed {
    slot_req_kind_e op;
    slot_addr_t     addr;
  } slot_req_op_t;

  typedef struct packed {
    slot_upd_kind_e op;
    slot_addr_t     addr;
    lane_max_t      maximum;
    lane_den_t      denominator;
  } slot_update_op_t;

  typedef struct packed {
    slot_t      slot;
    slot_addr_t addr;
    logic       err;
  } slot_rsp_t;

  function automatic slot_t slot_init();
    slot_t s;
    s = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      s.maximum[l] = SLOT_MAX_INIT;
    end
    s.valid = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/softex_slot_regfile_lzc.sv
// Leading/trailing zero counter (MODE=0: trailing).
// empty_o is high when no bit of in_i is set.
module softex_slot_regfile_lzc #(
  parameter int unsigned WIDTH = 4,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Scan from the far end so the position closest to the counted end wins.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if ((MODE == 1'b0) ? in_i[i] : in_i[int'(WIDTH) - 1 - i]) begin
        cnt_o   = CNT_W'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/softex_slot_regfile.sv
// Slot register file holding per-row running softmax statistics (lane maxima, denominators).
// ALLOC/LOAD requests get a registered response; UPDATE/FREE apply on the edge with no backpressure.
module softex_slot_regfile
  import softex_pkg::*;
#(
  parameter int unsigned  N_SLOTS = N_SLOTS_DEFAULT,
  localparam int unsigned IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  slot_req_op_t              req_op_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output slot_t                     rsp_slot_o,
  output logic [SLOT_ADDR_BITS-1:0] rsp_addr_o,
  output logic                      rsp_err_o,
  input  logic                      update_valid_i,
  input  slot_update_op_t           update_op_i,
  output logic                      upd_err_o,
  output logic                      full_o,
  output logic [IDX_W:0]            n_used_o
);

  logic [N_SLOTS-1:0] valid_q;
  lane_max_t          max_q [N_SLOTS];
  lane_den_t          den_q [N_SLOTS];
  logic               upd_err_q;
  logic               rsp_valid_q;
  slot_rsp_t          rsp_q;

  logic [N_SLOTS-1:0] upd_sel;
  logic [N_SLOTS-1:0] ld_sel;
  logic               upd_hit;
  logic               upd_fire;
  logic               req_fire;
  logic               alloc_fire;
  logic               bypass;
  logic               ld_hit;
  lane_max_t          ld_max;
  lane_den_t          ld_den;
  logic [IDX_W-1:0]   free_idx;
  logic               no_free;
  slot_rsp_t          rsp_d;
  logic [IDX_W:0]     n_used;

  // One-hot address decode; an all-zero vector means the address is out of range.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_dec
    assign upd_sel[gi] = (update_op_i.addr == SLOT_ADDR_BITS'(gi));
    assign ld_sel[gi]  = (req_op_i.addr == SLOT_ADDR_BITS'(gi));
  end

  softex_slot_regfile_lzc #(
    .WIDTH (N_SLOTS),
    .MODE  (1'b0)
  ) i_first_free (
    .in_i    (~valid_q),
    .cnt_o   (free_idx),
    .empty_o (no_free)
  );

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_fire    = req_valid_i && req_ready_o && !clear_i;
  assign upd_fire    = update_valid_i && !clear_i;
  assign upd_hit     = |(upd_sel & valid_q);
  assign alloc_fire  = req_fire && (req_op_i.op == SLOT_REQ_ALLOC) && !no_free;
  assign bypass      = upd_fire && upd_hit && (update_op_i.addr == req_op_i.addr);

  // LOAD read path; a same-cycle hit from the update port overrides storage.
  always_comb begin
    ld_max = '0;
    ld_den = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (ld_sel[i]) begin
        ld_max = max_q[i];
        ld_den = den_q[i];
      end
    end
    ld_hit = |(ld_sel & valid_q);
    if (bypass) begin
      if (update_op_i.op == SLOT_UPD_FREE) begin
        ld_hit = 1'b0;
      end else begin
        ld_max = update_op_i.maximum;
        ld_den = update_op_i.denominator;
      end
    end
  end

  always_comb begin
    rsp_d = '0;
    if (req_op_i.op == SLOT_REQ_ALLOC) begin
      if (no_free) begin
        rsp_d.err = 1'b1;
      end else begin
        rsp_d.slot = slot_init();
        rsp_d.addr = SLOT_ADDR_BITS'(free_idx);
      end
    end else begin
      rsp_d.addr = req_op_i.addr;
      if (ld_hit) begin
        rsp_d.slot.maximum     = ld_max;
        rsp_d.slot.denominator = ld_den;
        rsp_d.slot.valid       = 1'b1;
      end else begin
        rsp_d.err = 1'b1;
      end
    end
  end

  // Storage and valid bits. An update only touches a valid slot and ALLOC only
  // picks a slot that was invalid before this edge, so the two never collide.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      upd_err_q <= 1'b0;
    end else if (clear_i) begin
      valid_q   <= '0;
      upd_err_q <= 1'b0;
    end else begin
      if (update_valid_i) begin
        if (!upd_hit) begin
          upd_err_q <= 1'b1;
        end
        for (int i = 0; i < int'(N_SLOTS); i++) begin
          if (upd_sel[i] && valid_q[i]) begin
            if (update_op_i.op == SLOT_UPD_FREE) begin
              valid_q[i] <= 1'b0;
            end else begin
              max_q[i] <= update_op_i.maximum;
              den_q[i] <= update_op_i.denominator;
            end
          end
        end
      end
      if (alloc_fire) begin
        for (int i = 0; i < int'(N_SLOTS); i++) begin
          if (free_idx == IDX_W'(i)) begin
            valid_q[i] <= 1'b1;
            max_q[i]   <= {NUM_LANES{SLOT_MAX_INIT}};
            den_q[i]   <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (clear_i) begin
      rsp_valid_q <= 1'b0;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= rsp_d;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_comb begin
    n_used = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      n_used = n_used + (IDX_W+1)'(valid_q[i]);
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_slot_o  = rsp_q.slot;
  assign rsp_addr_o  = rsp_q.addr;
  assign rsp_err_o   = rsp_q.err;
  assign upd_err_o   = upd_err_q;
  assign full_o      = no_free;
  assign n_used_o    = n_used;

endmodule

// File: tb/tb_softex_slot_regfile.sv
// Self-checking bench for softex_slot_regfile: directed vectors and corner sequences,
// then random traffic checked against an array-based reference model.
module tb_softex_slot_regfile;
  import softex_pkg::*;

  localparam int N = 4;
  localparam int L = NUM_LANES;

  logic                      clk_i;
  logic                      rst_ni;
  logic                      clear_i;
  logic                      req_valid_i;
  logic                      req_ready_o;
  slot_req_op_t              req_op_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  slot_t                     rsp_slot_o;
  logic [SLOT_ADDR_BITS-1:0] rsp_addr_o;
  logic                      rsp_err_o;
  logic                      update_valid_i;
  slot_update_op_t           update_op_i;
  logic                      upd_err_o;
  logic                      full_o;
  logic [2:0]                n_used_o;

  softex_slot_regfile #(.N_SLOTS(N)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_slot_o     (rsp_slot_o),
    .rsp_addr_o     (rsp_addr_o),
    .rsp_err_o      (rsp_err_o),
    .update_valid_i (update_valid_i),
    .update_op_i    (update_op_i),
    .upd_err_o      (upd_err_o),
    .full_o         (full_o),
    .n_used_o       (n_used_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit                  m_valid [N];
  logic [WIDTH_IN-1:0] m_max   [N][L];
  logic [WIDTH_ACC-1:0] m_den  [N][L];
  bit                  m_uerr;
  bit                  m_rv;
  slot_rsp_t           m_rsp;

  typedef struct {
    logic [7:0] exp_addr;
    bit         exp_err;
    bit         exp_full;
    int         exp_used;
  } alloc_vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_used();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_valid[i];
    return c;
  endfunction

  function automatic slot_t m_slot(input int i);
    slot_t s;
    s = '0;
    s.valid = 1'b1;
    for (int l = 0; l < L; l++) begin
      s.maximum[l]     = m_max[i][l];
      s.denominator[l] = m_den[i][l];
    end
    return s;
  endfunction

  task automatic set_idle();
    rst_ni         = 1'b1;
    clear_i        = 1'b0;
    req_valid_i    = 1'b0;
    req_op_i       = '0;
    rsp_ready_i    = 1'b1;
    update_valid_i = 1'b0;
    update_op_i    = '0;
  endtask

  task automatic req(input slot_req_kind_e op, input logic [7:0] addr);
    req_valid_i   = 1'b1;
    req_op_i.op   = op;
    req_op_i.addr = addr;
  endtask

  task automatic upd(input slot_upd_kind_e op, input logic [7:0] addr,
                     input logic [15:0] mx, input logic [31:0] dn);
    update_valid_i   = 1'b1;
    update_op_i.op   = op;
    update_op_i.addr = addr;
    for (int l = 0; l < L; l++) begin
      update_op_i.maximum[l]     = mx;
      update_op_i.denominator[l] = dn;
    end
  endtask

  // One clock: check ready, advance the model with the driven inputs, check registered outputs.
  task automatic cycle();
    bit        acc;
    bit        pre [N];
    int        a;
    int        fi;
    slot_rsp_t r;
    #1;
    chk("req_ready", req_ready_o, !m_rv || rsp_ready_i);
    acc = req_valid_i && (!m_rv || rsp_ready_i) && !clear_i;
    if (!rst_ni) begin
      m_valid = '{default: 0};
      m_uerr  = 0;
      m_rv    = 0;
      m_rsp   = '0;
    end else if (clear_i) begin
      m_valid = '{default: 0};
      m_uerr  = 0;
      m_rv    = 0;
    end else begin
      pre = m_valid;
      if (update_valid_i) begin
        a = int'(update_op_i.addr);
        if (a < N && m_valid[a]) begin
          if (update_op_i.op == SLOT_UPD_FREE) m_valid[a] = 0;
          else begin
            for (int l = 0; l < L; l++) begin
              m_max[a][l] = update_op_i.maximum[l];
              m_den[a][l] = update_op_i.denominator[l];
            end
          end
        end else begin
          m_uerr = 1;
        end
      end
      if (acc) begin
        r = '0;
        if (req_op_i.op == SLOT_REQ_ALLOC) begin
          fi = -1;
          for (int i = 0; i < N; i++) if (!pre[i] && fi < 0) fi = i;
          if (fi >= 0) begin
            m_valid[fi] = 1;
            for (int l = 0; l < L; l++) begin
              m_max[fi][l] = 16'hFF80;
              m_den[fi][l] = 32'h0;
            end
            r.slot = m_slot(fi);
            r.addr = 8'(fi);
          end else begin
            r.err = 1'b1;
          end
        end else begin
          a      = int'(req_op_i.addr);
          r.addr = req_op_i.addr;
          if (a < N && m_valid[a]) r.slot = m_slot(a);
          else r.err = 1'b1;
        end
        m_rsp = r;
        m_rv  = 1;
      end else if (rsp_ready_i) begin
        m_rv = 0;
      end
    end
    @(posedge clk_i);
    #1;
    chk("rsp_valid", rsp_valid_o, m_rv);
    if (m_rv) begin
      chk("rsp_slot", rsp_slot_o, m_rsp.slot);
      chk("rsp_addr", rsp_addr_o, m_rsp.addr);
      chk("rsp_err", rsp_err_o, m_rsp.err);
    end
    chk("upd_err", upd_err_o, m_uerr);
    chk("n_used", n_used_o, m_used());
    chk("full", full_o, m_used() == N);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({tag, "_rsp_slot"}, rsp_slot_o, '0);
    chk({tag, "_rsp_addr"}, rsp_addr_o, 8'h00);
    chk({tag, "_rsp_err"}, rsp_err_o, 1'b0);
    chk({tag, "_upd_err"}, upd_err_o, 1'b0);
    chk({tag, "_full"}, full_o, 1'b0);
    chk({tag, "_n_used"}, n_used_o, 3'd0);
    chk({tag, "_req_ready"}, req_ready_o, 1'b1);
  endtask

  alloc_vec_t tbl [5];

  initial begin
    m_valid = '{default: 0};
    m_uerr  = 0;
    m_rv    = 0;
    m_rsp   = '0;
    set_idle();
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    cycle();
    chk_reset_state("reset");

    // Back-to-back ALLOCs until full, then one more.
    tbl[0] = '{8'd0, 1'b0, 1'b0, 1};
    tbl[1] = '{8'd1, 1'b0, 1'b0, 2};
    tbl[2] = '{8'd2, 1'b0, 1'b0, 3};
    tbl[3] = '{8'd3, 1'b0, 1'b1, 4};
    tbl[4] = '{8'd0, 1'b1, 1'b1, 4};
    for (int k = 0; k < 5; k++) begin
      set_idle();
      req(SLOT_REQ_ALLOC, 8'd0);
      cycle();
      chk($sformatf("alloc%0d_addr", k), rsp_addr_o, tbl[k].exp_addr);
      chk($sformatf("alloc%0d_err", k), rsp_err_o, tbl[k].exp_err);
      chk($sformatf("alloc%0d_full", k), full_o, tbl[k].exp_full);
      chk($sformatf("alloc%0d_used", k), n_used_o, tbl[k].exp_used);
    end

    set_idle();
    upd(SLOT_UPD_UPDATE, 8'd2, 16'h3F80, 32'h40000000);
    cycle();
    set_idle();
    req(SLOT_REQ_LOAD, 8'd2);
    cycle();
    chk("load2_max", rsp_slot_o.maximum, {4{16'h3F80}});
    chk("load2_den", rsp_slot_o.denominator, {4{32'h40000000}});
    chk("load2_valid", rsp_slot_o.valid, 1'b1);

    // Same-cycle UPDATE + LOAD: load sees the new data.
    set_idle();
    upd(SLOT_UPD_UPDATE, 8'd1, 16'h4110, 32'h3F000000);
    req(SLOT_REQ_LOAD, 8'd1);
    cycle();
    chk("bypass_max", rsp_slot_o.maximum, {4{16'h4110}});
    chk("bypass_den", rsp_slot_o.denominator, {4{32'h3F000000}});

    // FREE concurrent with ALLOC while full: the freed slot is not yet eligible.
    set_idle();
    upd(SLOT_UPD_FREE, 8'd1, 16'h0, 32'h0);
    req(SLOT_REQ_ALLOC, 8'd0);
    cycle();
    chk("free_alloc_err", rsp_err_o, 1'b1);
    chk("free_alloc_used", n_used_o, 3'd3);
    set_idle();
    req(SLOT_REQ_ALLOC, 8'd0);
    cycle();
    chk("realloc_addr", rsp_addr_o, 8'd1);
    chk("realloc_used", n_used_o, 3'd4);

    set_idle();
    req(SLOT_REQ_LOAD, 8'd9);
    cycle();
    chk("load9_err", rsp_err_o, 1'b1);
    chk("load9_addr", rsp_addr_o, 8'd9);

    set_idle();
    upd(SLOT_UPD_FREE, 8'd3, 16'h0, 32'h0);
    cycle();
    set_idle();
    upd(SLOT_UPD_UPDATE, 8'd3, 16'h1111, 32'h22222222);
    cycle();
    chk("upd_free_err", upd_err_o, 1'b1);
    set_idle();
    req(SLOT_REQ_LOAD, 8'd2);
    cycle();
    chk("untouched2_max", rsp_slot_o.maximum, {4{16'h3F80}});
    set_idle();
    clear_i = 1'b1;
    cycle();
    chk("clear_upd_err", upd_err_o, 1'b0);
    chk("clear_used", n_used_o, 3'd0);

    // Backpressure: response held for 3 cycles, second request waits.
    set_idle();
    req(SLOT_REQ_ALLOC, 8'd0);
    cycle();
    set_idle();
    rsp_ready_i = 1'b0;
    req(SLOT_REQ_LOAD, 8'd0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      req(SLOT_REQ_ALLOC, 8'd0);
      cycle();
      chk($sformatf("bp%0d_ready", k), req_ready_o, 1'b0);
      chk($sformatf("bp%0d_addr", k), rsp_addr_o, 8'd0);
      chk($sformatf("bp%0d_max", k), rsp_slot_o.maximum, {4{16'hFF80}});
      chk($sformatf("bp%0d_used", k), n_used_o, 3'd1);
    end
    rsp_ready_i = 1'b1;
    cycle();
    chk("bp_release_addr", rsp_addr_o, 8'd1);
    chk("bp_release_used", n_used_o, 3'd2);

    // Reset with a response in flight.
    set_idle();
    rsp_ready_i = 1'b0;
    req(SLOT_REQ_LOAD, 8'd1);
    cycle();
    set_idle();
    rsp_ready_i = 1'b0;
    rst_ni = 1'b0;
    cycle();
    chk_reset_state("midrst");

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst_ni         = ($urandom_range(0, 249) != 0);
      clear_i        = ($urandom_range(0, 59) == 0);
      rsp_ready_i    = ($urandom_range(0, 3) != 0);
      req_valid_i    = ($urandom_range(0, 2) != 0);
      req_op_i.op    = ($urandom_range(0, 1) == 0) ? SLOT_REQ_ALLOC : SLOT_REQ_LOAD;
      req_op_i.addr  = 8'($urandom_range(0, 5));
      update_valid_i = ($urandom_range(0, 2) == 0);
      update_op_i.op = ($urandom_range(0, 3) == 0) ? SLOT_UPD_FREE : SLOT_UPD_UPDATE;
      update_op_i.addr = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      update_op_i.maximum     = {$urandom, $urandom};
      update_op_i.denominator = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
